// File: rtl/rx_pkg.sv
// Shared types and constants for the PHY receive deframer and its optional CRC checker.
// The CRC checker is built only when RX_FCS_CHECK_EN is defined.
package rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  localparam logic [3:0] NIB_PREAMBLE = 4'h5;
  localparam logic [3:0] NIB_SFD      = 4'hD;

  localparam int CTRL_LEN_HI_MSB = 23;
  localparam int CTRL_LEN_HI_LSB = 12;
  localparam int CTRL_LEN_LO_MSB = 11;
  localparam int CTRL_LEN_LO_LSB = 0;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/rx_crc32_nibble.sv
// Reflected CRC-32 register advanced four bits per cycle (LSB-first nibble order).
// The register is left un-inverted so the caller can compare against the residue.
module rx_crc32_nibble
  import rx_pkg::*;
(
  input  logic        clk_phy,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [3:0]  nibble,
  output logic [31:0] crc
);

  localparam logic [31:0] POLY_REFL = bitrev32(CRC32_POLY);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q ^ {28'd0, nibble};
    for (int i = 0; i < 4; i++) begin
      crc_d = crc_d[0] ? ((crc_d >> 1) ^ POLY_REFL) : (crc_d >> 1);
    end
  end

  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      crc_q <= '1;
    end else if (init) begin
      crc_q <= '1;
    end else if (en) begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/phy_rx_deframer.sv
// Receive deframer: 4-bit PHY stream (0x5 preamble, 0xD SFD, low nibble first) to bytes
// plus an end-of-frame control block. Define RX_FCS_CHECK_EN to add the FCS residue check.
module phy_rx_deframer
  import rx_pkg::*;
#(
  parameter int MIN_LEN      = 64,
  parameter int MAX_LEN      = 1518,
  parameter int PREAMBLE_MIN = 2
) (
  input  logic        clk_phy,
  input  logic        reset,
  input  logic [3:0]  phy_data_in,
  input  logic        phy_rx_dv,
  output logic [7:0]  r_data_out,
  output logic        r_data_valid,
  output logic        r_frame_valid,
  output logic [23:0] r_ctrl_out,
  output logic        r_frame_err
);

  localparam logic [3:0]  PRE_MIN_W = 4'(PREAMBLE_MIN);
  localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);
  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);

  rx_state_e   state_q;
  logic [3:0]  pre_cnt_q;
  logic [3:0]  low_q;
  logic        phase_q;
  logic [11:0] len_q;
  logic [7:0]  data_q;
  logic        dvalid_q;
  logic        fvalid_q;
  logic [23:0] ctrl_q;
  logic        err_q;

  logic [11:0] len_d;
  logic        sfd_ok;
  logic        fcs_bad;
  logic        frame_err;

  assign len_d     = (&len_q) ? len_q : len_q + 12'd1;
  assign sfd_ok    = (phy_data_in == NIB_SFD) && (pre_cnt_q >= PRE_MIN_W);
  assign frame_err = phase_q | (len_q < MIN_LEN_W) | (len_q > MAX_LEN_W) | fcs_bad;

`ifdef RX_FCS_CHECK_EN
  logic [31:0] crc;
  logic        crc_init;
  logic        crc_en;

  assign crc_init = (state_q == ST_PREAMBLE) && phy_rx_dv && sfd_ok;
  assign crc_en   = (state_q == ST_DATA) && phy_rx_dv;

  rx_crc32_nibble u_crc (
    .clk_phy (clk_phy),
    .reset   (reset),
    .init    (crc_init),
    .en      (crc_en),
    .nibble  (phy_data_in),
    .crc     (crc)
  );

  // The register holds the reflected residue; compare in normal bit order.
  assign fcs_bad = (bitrev32(crc) != CRC32_RESIDUE);
`else
  assign fcs_bad = 1'b0;
`endif

  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pre_cnt_q <= '0;
      low_q     <= '0;
      phase_q   <= 1'b0;
      len_q     <= '0;
      data_q    <= '0;
      dvalid_q  <= 1'b0;
      fvalid_q  <= 1'b0;
      ctrl_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      dvalid_q <= 1'b0;
      fvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (phy_rx_dv) begin
            if (phy_data_in == NIB_PREAMBLE) begin
              state_q   <= ST_PREAMBLE;
              pre_cnt_q <= 4'd1;
            end else begin
              state_q <= ST_DROP;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!phy_rx_dv) begin
            state_q <= ST_IDLE;
          end else if (phy_data_in == NIB_PREAMBLE) begin
            if (pre_cnt_q != 4'hF) pre_cnt_q <= pre_cnt_q + 4'd1;
          end else if (sfd_ok) begin
            state_q <= ST_DATA;
            phase_q <= 1'b0;
            len_q   <= '0;
          end else begin
            state_q <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (phy_rx_dv) begin
            if (!phase_q) begin
              low_q   <= phy_data_in;
              phase_q <= 1'b1;
            end else begin
              data_q   <= {phy_data_in, low_q};
              dvalid_q <= 1'b1;
              len_q    <= len_d;
              phase_q  <= 1'b0;
            end
          end else begin
            // Carrier drop ends the frame; a dangling low nibble is discarded.
            state_q  <= ST_IDLE;
            fvalid_q <= 1'b1;
            ctrl_q[CTRL_LEN_HI_MSB:CTRL_LEN_HI_LSB] <= len_q;
            ctrl_q[CTRL_LEN_LO_MSB:CTRL_LEN_LO_LSB] <= len_q;
            err_q    <= frame_err;
          end
        end
        ST_DROP: begin
          if (!phy_rx_dv) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign r_data_out    = data_q;
  assign r_data_valid  = dvalid_q;
  assign r_frame_valid = fvalid_q;
  assign r_ctrl_out    = ctrl_q;
  assign r_frame_err   = err_q;

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Scoreboard bench for phy_rx_deframer: stimulus pushes expected bytes/frames, a monitor pops and compares.
module tb_phy_rx_deframer;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int PRE_MIN = 2;

  logic        clk_phy = 1'b0;
  logic        reset   = 1'b0;
  logic [3:0]  phy_data_in = 4'h0;
  logic        phy_rx_dv   = 1'b0;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic        r_frame_valid;
  logic [23:0] r_ctrl_out;
  logic        r_frame_err;

  phy_rx_deframer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .PREAMBLE_MIN(PRE_MIN)) dut (
    .clk_phy       (clk_phy),
    .reset         (reset),
    .phy_data_in   (phy_data_in),
    .phy_rx_dv     (phy_rx_dv),
    .r_data_out    (r_data_out),
    .r_data_valid  (r_data_valid),
    .r_frame_valid (r_frame_valid),
    .r_ctrl_out    (r_ctrl_out),
    .r_frame_err   (r_frame_err)
  );

  always #5 clk_phy = ~clk_phy;

  typedef struct {
    logic [23:0] ctrl;
    logic        err;
  } fexp_t;

  logic [7:0] bq[$];
  fexp_t      fq[$];
  logic [7:0] fbuf [0:2047];
  int checks = 0;
  int errors = 0;
  int frames_seen = 0;
  logic prev_dv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc32_fcs(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, fbuf[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic add_fcs(input int n);
    logic [31:0] f = crc32_fcs(n - 4);
    for (int k = 0; k < 4; k++) fbuf[n-4+k] = f[8*k +: 8];
  endtask

  task automatic drv(input logic [3:0] n);
    @(posedge clk_phy);
    #1;
    phy_rx_dv   = 1'b1;
    phy_data_in = n;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk_phy);
      #1;
      phy_rx_dv   = 1'b0;
      phy_data_in = 4'($urandom);
    end
  endtask

  // pre_n 0x5 nibbles (bad_idx >= 0 replaces one with 0xA), SFD, fbuf[0..nbytes-1], optional stray nibble.
  task automatic send_frame(input int pre_n, input int bad_idx, input int nbytes, input bit odd, input int gap);
    bit    ok;
    bit    fcs_bad;
    fexp_t fe;
    ok = (bad_idx < 0) && (pre_n >= PRE_MIN);
    for (int i = 0; i < pre_n; i++) drv((i == bad_idx) ? 4'hA : 4'h5);
    drv(4'hD);
    for (int i = 0; i < nbytes; i++) begin
      drv(fbuf[i][3:0]);
      if (ok) bq.push_back(fbuf[i]);
      drv(fbuf[i][7:4]);
    end
    if (odd) drv(4'($urandom));
    fcs_bad = 1'b0;
`ifdef RX_FCS_CHECK_EN
    fcs_bad = (nbytes < 4) || (crc32_fcs(nbytes - 4) != {fbuf[nbytes-1], fbuf[nbytes-2], fbuf[nbytes-3], fbuf[nbytes-4]});
`endif
    if (ok) begin
      fe.ctrl = {12'(nbytes), 12'(nbytes)};
      fe.err  = odd || (nbytes < MIN_LEN) || (nbytes > MAX_LEN) || fcs_bad;
      fq.push_back(fe);
    end
    idle(gap);
  endtask

  task automatic fill(input int n, input logic [7:0] v, input bit rnd);
    for (int i = 0; i < n; i++) fbuf[i] = rnd ? 8'($urandom) : v;
  endtask

  always @(negedge clk_phy) begin
    if (reset) begin
      if (r_data_valid) begin
        check("dv_spacing", {31'd0, prev_dv}, 32'd0);
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL byte_unexpected: got 0x%0h expected none", r_data_out);
        end else begin
          check("byte", {24'd0, r_data_out}, {24'd0, bq.pop_front()});
        end
      end
      if (r_frame_valid) begin
        frames_seen++;
        check("fv_with_dv", {31'd0, r_data_valid}, 32'd0);
        if (fq.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexpected: got ctrl 0x%0h expected none", r_ctrl_out);
        end else begin
          fexp_t fe;
          fe = fq.pop_front();
          check("ctrl", {8'd0, r_ctrl_out}, {8'd0, fe.ctrl});
          check("err", {31'd0, r_frame_err}, {31'd0, fe.err});
        end
      end
      prev_dv = r_data_valid;
    end else begin
      prev_dv = 1'b0;
    end
  end

  initial begin
    #1;
    check("rst_dv", {31'd0, r_data_valid}, 32'd0);
    check("rst_fv", {31'd0, r_frame_valid}, 32'd0);
    check("rst_ctrl", {8'd0, r_ctrl_out}, 32'd0);
    check("rst_err", {31'd0, r_frame_err}, 32'd0);
    repeat (3) @(posedge clk_phy);
    #1 reset = 1'b1;
    idle(2);

    fill(64, 8'h00, 0);
    send_frame(15, -1, 64, 0, 3);

    fill(512, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin fbuf[i] = 8'hFF; fbuf[508+i] = 8'hFF; end
    send_frame(7, -1, 512, 0, 3);

    fill(20, 0, 1);
    send_frame(7, -1, 20, 0, 2);
    fill(1600, 0, 1);
    send_frame(7, -1, 1600, 0, 2);
    fill(64, 0, 1);
    send_frame(7, -1, 64, 1, 2);
    send_frame(8, 0, 64, 0, 2);
    send_frame(1, -1, 64, 0, 2);
    send_frame(20, -1, 70, 0, 2);

    // Reset mid-frame after byte 30, with the carrier still up.
    for (int i = 0; i < 40; i++) fbuf[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 7; i++) drv(4'h5);
    drv(4'hD);
    for (int i = 0; i < 30; i++) begin
      drv(fbuf[i][3:0]);
      bq.push_back(fbuf[i]);
      drv(fbuf[i][7:4]);
    end
    drv(fbuf[30][3:0]);
    @(posedge clk_phy);
    #1 reset = 1'b0;
    phy_rx_dv = 1'b0;
    #1;
    check("mid_rst_dv", {31'd0, r_data_valid}, 32'd0);
    check("mid_rst_data", {24'd0, r_data_out}, 32'd0);
    check("mid_rst_ctrl", {8'd0, r_ctrl_out}, 32'd0);
    check("mid_rst_fv", {31'd0, r_frame_valid}, 32'd0);
    check("mid_rst_bytes_left", bq.size(), 32'd0);
    repeat (2) @(posedge clk_phy);
    #1 reset = 1'b1;
    fill(64, 0, 1);
    send_frame(5, -1, 64, 0, 3);

    fill(64, 8'h00, 0);
    send_frame(15, -1, 64, 0, 1);
    send_frame(15, -1, 64, 0, 3);

`ifdef RX_FCS_CHECK_EN
    fill(64, 0, 1);
    add_fcs(64);
    send_frame(7, -1, 64, 0, 2);
    fbuf[62] = fbuf[62] ^ 8'h10;
    send_frame(7, -1, 64, 0, 2);
`endif

    for (int f = 0; f < 30; f++) begin
      int pre_n, bad_idx, nb;
      pre_n   = $urandom_range(0, 18);
      bad_idx = (pre_n > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, pre_n - 1) : -1;
      nb      = ($urandom_range(0, 1) == 0) ? $urandom_range(60, 80) : $urandom_range(1, 100);
      fill(nb, 0, 1);
`ifdef RX_FCS_CHECK_EN
      if (nb >= 8 && $urandom_range(0, 1) == 1) add_fcs(nb);
`endif
      send_frame(pre_n, bad_idx, nb, ($urandom_range(0, 5) == 0), $urandom_range(1, 3));
    end

    idle(10);
    check("bytes_pending", bq.size(), 32'd0);
    check("frames_pending", fq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phy_rx_deframer.md
Name: phy_rx_deframer

Overview:
Receive-side counterpart of the transmit path. Accepts the 4-bit PHY nibble stream with its data-valid strobe, which runs low nibble first and is framed by a 0x5 preamble and a 0xD SFD. Reassembles the stream into bytes and emits the same byte-plus-control-block interface the transmit side consumes: data bytes with a valid strobe, then a one-cycle frame-valid pulse carrying the 24-bit control block.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (inclusive)
MAX_LEN, 1518, maximum legal frame length in bytes (inclusive)
PREAMBLE_MIN, 2, minimum number of 0x5 nibbles required before SFD

Ports:
clk_phy  in  1  PHY nibble clock; sole clock
reset  in  1  asynchronous, active-low reset
phy_data_in  in  4  received nibble, low nibble of each byte first
phy_rx_dv  in  1  nibble valid / carrier
r_data_out  out  8  assembled data byte
r_data_valid  out  1  r_data_out valid, one cycle per byte
r_frame_valid  out  1  one-cycle pulse at end of frame
r_ctrl_out  out  24  control block {len[11:0], len[11:0]}, valid with r_frame_valid
r_frame_err  out  1  frame error flag, valid with r_frame_valid; downstream discards the frame

Behaviour:
- Reset (asserted low, async): all outputs 0, state IDLE, counters 0. Reset mid-frame abandons the frame; no r_frame_valid is emitted for it.
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - rx_dv=1 and nibble==0x5 -> PREAMBLE, pre_cnt=1.
  - rx_dv=1 and any other nibble -> DROP.
- PREAMBLE:
  - nibble 0x5 -> pre_cnt++, saturating at 15.
  - nibble 0xD and pre_cnt>=PREAMBLE_MIN -> DATA, phase=0, len=0.
  - 0xD too early, or any other nibble -> DROP.
  - rx_dv=0 -> IDLE; no outputs.
- DATA, rx_dv=1:
  - phase 0 latches the low nibble.
  - phase 1 forms the byte {nibble, low}.
  - r_data_out/r_data_valid are registered: valid the cycle after the high nibble is sampled.
  - len increments per byte, saturating at 4095.
- DATA, rx_dv=0 (end of frame) -> IDLE. Next cycle:
  - r_frame_valid=1, r_ctrl_out={len,len}.
  - r_frame_err = (phase==1, i.e. odd nibble count) | (len<MIN_LEN) | (len>MAX_LEN).
  - A trailing odd nibble is dropped and no byte is emitted for it.
- Frame-end timing:
  - The last r_data_valid and r_frame_valid never coincide; the pulse follows the last byte by at least 1 cycle.
  - r_ctrl_out holds its value until the next frame end.
- DROP: no outputs; wait for rx_dv=0, then IDLE.
- Back-to-back frames:
  - A 1-cycle rx_dv gap is legal.
  - The frame_valid pulse of frame N may coincide with preamble nibbles of frame N+1.
- Throughput: at most one byte every 2 cycles; r_data_valid is never high in consecutive cycles.

Optional Feature:
RX_FCS_CHECK_EN:
- Defined:
  - A nibble-wide CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over every DATA nibble.
  - At frame end, a residue not equal to 0xC704DD7B additionally sets r_frame_err.
  - FCS bytes are still passed on r_data_out and counted in len.
  - CRC is reset on SFD.
- Undefined: no CRC logic; r_frame_err is based on length and alignment only.

Decomposition:
- Shared package rx_pkg:
  - state enum.
  - NIB_PREAMBLE=4'h5, NIB_SFD=4'hD.
  - CTRL_LEN_HI=23:12, CTRL_LEN_LO=11:0.
  - CRC32_POLY and CRC32_RESIDUE constants.
- One sub-module, rx_crc32_nibble: ports clk_phy, reset, init, en, nibble[3:0], crc[31:0]. Instantiated only under RX_FCS_CHECK_EN.

Test Plan:
- 64-byte frame:
  - Stimulus: 15×0x5, 0xD, 64 bytes of 0x00.
  - Response: 64 r_data_valid pulses of 0x00; r_frame_valid with ctrl=0x040040, err=0.
- 512-byte frame:
  - Stimulus: 4×0xFF, 504×0x00, 4×0xFF (bytes sent low nibble first).
  - Response: same byte sequence out; ctrl=0x200200, err=0.
- Length errors:
  - 20-byte frame -> ctrl=0x014014, err=1.
  - 1600-byte frame -> ctrl=0x640640, err=1.
- Odd alignment and bad framing:
  - 64 bytes plus one extra nibble -> 64 bytes out, err=1.
  - Frame starting 0xA -> no outputs.
  - SFD after 1 preamble nibble -> no outputs.
- Reset mid-frame:
  - Stimulus: reset asserted after byte 30 with rx_dv still high.
  - Response: outputs 0 immediately; no frame_valid; following good 64-byte frame received correctly.
- Back-to-back:
  - Stimulus: two 64-byte frames with a 1-cycle gap.
  - Response: two frame_valid pulses, both ctrl=0x040040 and err=0; 128 bytes total.
  - With RX_FCS_CHECK_EN, a corrupted FCS byte -> err=1.
